// File: rtl/uart_tx_frame.sv
// uart_tx_frame: UART transmitter, 5..8 data bits, none/even/odd parity, 1-2 stop bits.
// Define UART_TX_FIFO_EN to add a FIFO_DEPTH-entry input FIFO for back-to-back frames.
module uart_tx_frame #(
  parameter int CLK_FREQ_HZ = 30000000,
  parameter int BAUD_RATE   = 115200,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [DATA_BITS-1:0] i_data,
  input  logic                 i_valid,
  output logic                 o_ready,
  output logic                 o_uart_tx,
  output logic                 o_busy
);
  localparam int DIV = CLK_FREQ_HZ / BAUD_RATE;
  localparam int CW  = (DIV < 2) ? 1 : $clog2(DIV);
  localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);
  localparam logic LAST_STOP = 1'(STOP_BITS - 1);
  localparam logic ODD = (PARITY_MODE == 2);
`ifdef UART_TX_FIFO_EN
  localparam bit FIFO_EN = 1'b1;
`else
  localparam bit FIFO_EN = 1'b0;
`endif

  if (DIV < 2) begin : g_bad_div
    $error("uart_tx_frame: CLK_FREQ_HZ / BAUD_RATE must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_width
    $error("uart_tx_frame: DATA_BITS must be 5..8");
  end
  if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_par
    $error("uart_tx_frame: PARITY_MODE must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_frame: STOP_BITS must be 1 or 2");
  end
  if (FIFO_EN && (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("uart_tx_frame: FIFO_DEPTH must be a power of two >= 2");
  end

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t               state, state_d;
  logic [CW-1:0]        cnt, cnt_d;
  logic [2:0]           bit_idx, bit_d;
  logic                 stop_idx, stop_d;
  logic [DATA_BITS-1:0] shreg, sh_d, word;
  logic                 par_q, par_d, tx_d;
  logic                 rdy_en, load, start_req, chain_req;

`ifdef UART_TX_FIFO_EN
  localparam int AW = (FIFO_DEPTH < 2) ? 1 : $clog2(FIFO_DEPTH);
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [AW:0]          count;
  logic                 push, pop, avail, full;

  assign full      = (count == (AW+1)'(FIFO_DEPTH));
  assign avail     = (count != '0);
  assign o_ready   = rdy_en & ~full;
  assign push      = i_valid & o_ready;
  assign pop       = load;
  assign start_req = avail;
  assign chain_req = avail;
  assign word      = mem[rd_ptr];
  assign o_busy    = (state != S_IDLE) | avail;

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= i_data;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end
`else
  assign o_ready   = rdy_en & (state == S_IDLE);
  assign start_req = i_valid & o_ready;
  assign chain_req = 1'b0;
  assign word      = i_data;
  assign o_busy    = (state != S_IDLE);
`endif

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    bit_d   = bit_idx;
    stop_d  = stop_idx;
    sh_d    = shreg;
    par_d   = par_q;
    load    = 1'b0;
    if (state != S_IDLE) cnt_d = cnt - 1'b1;
    case (state)
      S_IDLE: if (start_req) load = 1'b1;
      S_START: if (cnt == '0) begin
        state_d = S_DATA;
        bit_d   = '0;
        cnt_d   = RELOAD;
      end
      S_DATA: if (cnt == '0) begin
        cnt_d = RELOAD;
        sh_d  = shreg >> 1;
        if (bit_idx == LAST_BIT) begin
          state_d = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
          stop_d  = 1'b0;
        end else begin
          bit_d = bit_idx + 1'b1;
        end
      end
      S_PARITY: if (cnt == '0) begin
        state_d = S_STOP;
        stop_d  = 1'b0;
        cnt_d   = RELOAD;
      end
      S_STOP: if (cnt == '0) begin
        if (stop_idx != LAST_STOP) begin
          stop_d = 1'b1;
          cnt_d  = RELOAD;
        end else if (chain_req) begin
          load = 1'b1;
        end else begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // parity is taken from the word as it is latched, not from the live input
    if (load) begin
      state_d = S_START;
      cnt_d   = RELOAD;
      sh_d    = word;
      par_d   = (^word) ^ ODD;
    end
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = sh_d[0];
      S_PARITY: tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      stop_idx  <= 1'b0;
      shreg     <= '0;
      par_q     <= 1'b0;
      o_uart_tx <= 1'b1;
      rdy_en    <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      bit_idx   <= bit_d;
      stop_idx  <= stop_d;
      shreg     <= sh_d;
      par_q     <= par_d;
      o_uart_tx <= tx_d;
      rdy_en    <= 1'b1;
    end
  end
endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: four configurations (8N1, 8E1, 8O1, 5N2) at DIV = 10,
// line decoded cycle by cycle and compared against a scoreboard of expected frames.
module tb_uart_tx_frame;
  localparam int DIV = 1000000 / 100000;

  logic       clk, rst;
  logic [7:0] din  [4];
  logic       vld  [4];
  logic       rdy  [4];
  logic       tx   [4];
  logic       busy [4];

  int nb_c [4] = '{8, 8, 8, 5};
  int pm_c [4] = '{0, 1, 2, 0};
  int ns_c [4] = '{1, 1, 1, 2};

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q [$];

  uart_tx_frame #(.CLK_FREQ_HZ(1000000), .BAUD_RATE(100000), .DATA_BITS(8),
                  .PARITY_MODE(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8n1 (
    .i_clk(clk), .i_rst(rst), .i_data(din[0]), .i_valid(vld[0]),
    .o_ready(rdy[0]), .o_uart_tx(tx[0]), .o_busy(busy[0]));
  uart_tx_frame #(.CLK_FREQ_HZ(1000000), .BAUD_RATE(100000), .DATA_BITS(8),
                  .PARITY_MODE(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8e1 (
    .i_clk(clk), .i_rst(rst), .i_data(din[1]), .i_valid(vld[1]),
    .o_ready(rdy[1]), .o_uart_tx(tx[1]), .o_busy(busy[1]));
  uart_tx_frame #(.CLK_FREQ_HZ(1000000), .BAUD_RATE(100000), .DATA_BITS(8),
                  .PARITY_MODE(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8o1 (
    .i_clk(clk), .i_rst(rst), .i_data(din[2]), .i_valid(vld[2]),
    .o_ready(rdy[2]), .o_uart_tx(tx[2]), .o_busy(busy[2]));
  uart_tx_frame #(.CLK_FREQ_HZ(1000000), .BAUD_RATE(100000), .DATA_BITS(5),
                  .PARITY_MODE(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u_5n2 (
    .i_clk(clk), .i_rst(rst), .i_data(din[3][4:0]), .i_valid(vld[3]),
    .o_ready(rdy[3]), .o_uart_tx(tx[3]), .o_busy(busy[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks so far %0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int flen(input int idx);
    return 1 + nb_c[idx] + int'(pm_c[idx] != 0) + ns_c[idx];
  endfunction

  // line bits LSB first: start, payload, optional parity, stop bits (upper bits idle-high)
  function automatic logic [15:0] mk(input int idx, input logic [7:0] d);
    logic [15:0] f = '1;
    logic par = (pm_c[idx] == 2);
    f[0] = 1'b0;
    for (int i = 0; i < nb_c[idx]; i++) begin
      f[1+i] = d[i];
      par ^= d[i];
    end
    if (pm_c[idx] != 0) f[1+nb_c[idx]] = par;
    return f;
  endfunction

  task automatic send(input int idx, input logic [7:0] d, input bit track);
    int n = 0;
    @(negedge clk);
    din[idx] = d;
    vld[idx] = 1'b1;
    while (!rdy[idx] && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("hs_wait", 32'(n < 2000), 1);
    @(posedge clk);
    if (track) exp_q.push_back(mk(idx, d));
    @(negedge clk);
    vld[idx] = 1'b0;
  endtask

  task automatic rx_frame(input int idx, output int gap);
    logic [15:0] obs = '1;
    int bad = 0;
    int len = flen(idx);
    gap = 0;
    @(negedge clk);
    while (tx[idx] !== 1'b0 && gap < 3000) begin
      @(negedge clk);
      gap++;
    end
    chk("start_seen", 32'(gap < 3000), 1);
    if (gap >= 3000) return;
    chk("busy_on", busy[idx], 1);
    for (int i = 0; i < len * DIV; i++) begin
      if (i > 0) @(negedge clk);
      if (i % DIV == 0) obs[i/DIV] = tx[idx];
      else if (tx[idx] !== obs[i/DIV]) bad++;
    end
    chk("bit_hold", bad, 0);
    chk("sb_pending", 32'(exp_q.size() != 0), 1);
    if (exp_q.size() != 0) chk("frame", obs, exp_q.pop_front());
  endtask

  initial begin
    int n, g;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      vld[i] = 1'b0;
      din[i] = '0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk("rst_tx", tx[i], 1);
      chk("rst_rdy", rdy[i], 0);
      chk("rst_busy", busy[i], 0);
    end
    rst = 1'b0;
    #1 chk("rdy_before_edge", rdy[0], 0);
    @(negedge clk);
    chk("rdy_rise", rdy[0], 1);

    // 8N1 0xA5, plus o_ready return time
    fork
      begin
        send(0, 8'hA5, 1'b1);
`ifndef UART_TX_FIFO_EN
        n = 0;
        while (!rdy[0] && n < 500) begin
          n++;
          @(negedge clk);
        end
        chk("rdy_return", n, 100);
`endif
      end
      rx_frame(0, g);
    join

    fork send(1, 8'h07, 1'b1); rx_frame(1, g); join
    fork send(2, 8'h07, 1'b1); rx_frame(2, g); join
    fork send(3, 8'h1F, 1'b1); rx_frame(3, g); join
    fork send(3, 8'hE3, 1'b1); rx_frame(3, g); join
    fork send(1, 8'hC8, 1'b1); rx_frame(1, g); join

`ifndef UART_TX_FIFO_EN
    // valid held while busy with changing data: only the handshake value is sent
    fork
      begin
        send(0, 8'h5A, 1'b1);
        vld[0] = 1'b1;
        for (int i = 0; i < 20; i++) begin
          din[0] = 8'($urandom);
          chk("hold_rdy_low", rdy[0], 0);
          @(negedge clk);
        end
        send(0, 8'hC3, 1'b1);
      end
      begin
        rx_frame(0, g);
        rx_frame(0, g);
        chk("idle_gap", g, 1);
      end
    join
`endif

    // reset mid-frame of 0x00, then a fresh frame
    send(0, 8'h00, 1'b0);
    repeat (34) @(negedge clk);
    chk("pre_rst_line", tx[0], 0);
    rst = 1'b1;
    #1;
    chk("rst_line_async", tx[0], 1);
    chk("rst_rdy_mid", rdy[0], 0);
    chk("rst_busy_mid", busy[0], 0);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    repeat (30) begin
      @(negedge clk);
      if (tx[0] !== 1'b1) n++;
    end
    chk("no_stale_bits", n, 0);
    fork send(0, 8'h3C, 1'b1); rx_frame(0, g); join

`ifdef UART_TX_FIFO_EN
    fork
      begin
        @(negedge clk);
        vld[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
          din[0] = 8'(8'h11 * (i + 1));
          n = 0;
          while (!rdy[0] && n < 2000) begin
            @(negedge clk);
            n++;
          end
          chk("fifo_hs", 32'(n < 2000), 1);
          @(posedge clk);
          exp_q.push_back(mk(0, din[0]));
          @(negedge clk);
        end
        chk("fifo_full_rdy", rdy[0], 0);
        vld[0] = 1'b0;
      end
      begin
        for (int i = 0; i < 5; i++) begin
          rx_frame(0, g);
          if (i > 0) chk("fifo_gap", g, 0);
        end
        @(negedge clk);
        chk("busy_end", busy[0], 0);
      end
    join
`endif

    chk("sb_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
